// File: rtl/mpsoc_ahb3_spram_ws_pkg.sv
// Shared definitions for the AHB3-Lite single-port RAM slave with wait states.
// Holds the HTRANS and HRESP encodings, the data-phase FSM state type and a
// helper that decides whether a byte address is aligned to a transfer size.
package mpsoc_ahb3_spram_ws_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    // True when the low address bits are not a multiple of 2**size bytes.
    function automatic logic misaligned(input logic [2:0] lsb, input logic [2:0] size);
        logic m;
        case (size)
            3'd0:    m = 1'b0;
            3'd1:    m = lsb[0];
            3'd2:    m = |lsb[1:0];
            default: m = |lsb;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mpsoc_ram_1r1w_be.sv
// Word-organised RAM with a byte-enabled synchronous write port and an
// asynchronous read port. Contents are never reset.
//   clk_i    write clock (rising edge)
//   we_i     write strobe
//   be_i     per-byte write enables
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
module mpsoc_ram_1r1w_be #(
    parameter int DEPTH = 256,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mpsoc_ahb3_spram_ws.sv
// AHB3-Lite slave wrapping a single-port RAM with a configurable number of
// data-phase wait states for OKAY transfers and a two-cycle ERROR response for
// out-of-range, oversized or misaligned accesses.
//   HCLK/HRESETn        clock, asynchronous active-low reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY   address-phase inputs
//   HBURST/HPROT/HMASTLOCK                  accepted but unused
//   HWDATA              write data (data phase)
//   HRDATA              read data, held between reads
//   HREADYOUT/HRESP     slave handshake and response
module mpsoc_ahb3_spram_ws
    import mpsoc_ahb3_spram_ws_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int PLEN        = 10,
    parameter int XLEN        = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int              NB       = XLEN / 8;
    localparam int              BSH      = $clog2(NB);
    localparam int              AW       = $clog2(MEM_DEPTH);
    localparam logic [PLEN:0]   LIMIT    = (PLEN+1)'(MEM_DEPTH * NB);
    localparam logic [2:0]      MAX_SIZE = 3'(BSH);
    localparam logic [2:0]      WS_LOAD  = 3'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              dphase_q, dphase_d;
    logic [PLEN-1:0]   addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [XLEN-1:0]   rdata_q;

    logic              xfer_req, accept, req_err, ready_out, final_ok, rd_final;
    logic [BSH-1:0]    off;
    logic [NB-1:0]     be;
    logic [AW-1:0]     widx;
    logic [XLEN-1:0]   ram_rdata;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    always_comb begin
        xfer_req = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: xfer_req = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  xfer_req = 1'b0;
            default:                   xfer_req = 1'b0;
        endcase
    end

    // HREADYOUT is also gated into acceptance so that a master that fails to
    // stall HREADY cannot overwrite the registered address mid-transfer.
    assign ready_out = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept    = HSEL && HREADY && ready_out && xfer_req;
    assign req_err   = ({1'b0, HADDR} >= LIMIT) || (HSIZE > MAX_SIZE) ||
                       misaligned(HADDR[2:0], HSIZE);

    // An OKAY transfer completes in IDLE: either immediately (no wait states)
    // or after WAIT has drained its counter.
    assign final_ok  = (state_q == ST_IDLE) && dphase_q;
    assign rd_final  = final_ok && !write_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = ready_out ? accept : dphase_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            dphase_q <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (rd_final) rdata_q <= ram_rdata;
        end
    end

    // Byte lanes covered by the registered size starting at the address offset.
    assign off = addr_q[BSH-1:0];
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(off)) && (i < int'(off) + (1 << int'(size_q)))) be[i] = 1'b1;
        end
    end

    assign widx = AW'(addr_q >> BSH);

    mpsoc_ram_1r1w_be #(
        .DEPTH (MEM_DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (final_ok && write_q),
        .be_i    (be),
        .waddr_i (widx),
        .wdata_i (HWDATA),
        .raddr_i (widx),
        .rdata_o (ram_rdata)
    );

    // Read data bypasses the hold register during the final read cycle so the
    // addressed word appears in that cycle rather than one later.
    assign HRDATA    = rd_final ? ram_rdata : rdata_q;
    assign HREADYOUT = ready_out;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_mpsoc_ahb3_spram_ws.sv
module tb_mpsoc_ahb3_spram_ws;
    import mpsoc_ahb3_spram_ws_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hsel      [2];
    logic [11:0] haddr     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [1:0]  htrans    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mb [2][1024];

    // Instance 0: no wait states. Instance 1: three wait states.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mpsoc_ahb3_spram_ws #(
            .MEM_DEPTH   (256),
            .PLEN        (12),
            .XLEN        (32),
            .WAIT_STATES (g * 3)
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HTRANS    (htrans[g]),
            .HMASTLOCK (1'b0),
            .HREADY    (hreadyout[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        int          d;
        bit          wr;
        logic [11:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        bit          chkd;
        logic [31:0] ed;
        bit          er;
        int          ew;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    // One complete non-pipelined transfer; returns at the negedge of the last data-phase cycle.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit junk,
                        output logic [31:0] rd, output bit r_or, output bit r_and,
                        output int waits, output bit tmo);
        bit done;
        @(posedge clk); #1;
        hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
        @(posedge clk); #1;
        hwdata[d] = wd;
        if (junk) begin
            haddr[d] = a ^ 12'h004; hwrite[d] = 1'b1; hsize[d] = 3'd2;
        end else begin
            hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
        end
        rd = '0; r_or = 1'b0; r_and = 1'b1; waits = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            r_or  = r_or | hresp[d];
            r_and = r_and & hresp[d];
            if (hreadyout[d]) begin
                rd = hrdata[d]; done = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
                hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
            end
        end
        tmo = !done;
    endtask

    // Reference: byte-addressed memory image with the slave's error rules.
    task automatic mxfer(input int d, input bit wr, input logic [11:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        logic [31:0] rd, exp;
        bit r_or, r_and, tmo, err;
        int waits, ew, base, nbytes;
        nbytes = 1 << int'(sz);
        err = (a >= 12'h400) || (sz > 3'd2) || ((int'(a) % nbytes) != 0);
        ew  = err ? 1 : (d == 1 ? 3 : 0);
        xfer(d, wr, a, sz, wd, 1'b0, rd, r_or, r_and, waits, tmo);
        check("rnd_timeout", 32'(tmo), 32'd0);
        check("rnd_resp", {30'd0, r_or, r_and}, {30'd0, err, err});
        check("rnd_waits", 32'(waits), 32'(ew));
        if (!err) begin
            base = int'(a) & ~3;
            if (wr) begin
                for (int k = 0; k < nbytes; k++)
                    mb[d][int'(a) + k] = wd[((int'(a) + k) % 4) * 8 +: 8];
            end else begin
                exp = {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
                check("rnd_rdata", rd, exp);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        bit r_or, r_and, tmo;
        int waits;
        logic [11:0] ra;
        logic [2:0]  rs;

        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = '0; hwdata[d] = '0; hwrite[d] = 1'b0;
            hsize[d] = 3'd2; htrans[d] = HTRANS_IDLE;
        end
        #1 rst_n = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            check("reset_hreadyout", 32'(hreadyout[d]), 32'd1);
            check("reset_hresp", 32'(hresp[d]), 32'd0);
            check("reset_hrdata", hrdata[d], 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        tbl.push_back(vec_t'{0, 1, 12'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0,        0, 0});
        tbl.push_back(vec_t'{0, 0, 12'h010, 3'd2, 32'h0,        1, 32'hDEADBEEF, 0, 0});
        tbl.push_back(vec_t'{1, 1, 12'h020, 3'd2, 32'h00000000, 0, 32'h0,        0, 3});
        tbl.push_back(vec_t'{1, 1, 12'h020, 3'd0, 32'h00000011, 0, 32'h0,        0, 3});
        tbl.push_back(vec_t'{1, 1, 12'h023, 3'd0, 32'h22000000, 0, 32'h0,        0, 3});
        tbl.push_back(vec_t'{1, 0, 12'h020, 3'd2, 32'h0,        1, 32'h22000011, 0, 3});
        tbl.push_back(vec_t'{1, 1, 12'h022, 3'd1, 32'h77660000, 0, 32'h0,        0, 3});
        tbl.push_back(vec_t'{1, 0, 12'h021, 3'd0, 32'h0,        1, 32'h77660011, 0, 3});
        tbl.push_back(vec_t'{0, 1, 12'h000, 3'd2, 32'h12345678, 0, 32'h0,        0, 0});
        tbl.push_back(vec_t'{0, 1, 12'h400, 3'd2, 32'hFFFFFFFF, 0, 32'h0,        1, 1});
        tbl.push_back(vec_t'{0, 0, 12'h000, 3'd2, 32'h0,        1, 32'h12345678, 0, 0});
        tbl.push_back(vec_t'{0, 1, 12'h001, 3'd1, 32'hAAAAAAAA, 0, 32'h0,        1, 1});
        tbl.push_back(vec_t'{0, 0, 12'h000, 3'd2, 32'h0,        1, 32'h12345678, 0, 0});
        tbl.push_back(vec_t'{0, 0, 12'h008, 3'd3, 32'h0,        0, 32'h0,        1, 1});
        tbl.push_back(vec_t'{1, 0, 12'h400, 3'd2, 32'h0,        0, 32'h0,        1, 1});
        tbl.push_back(vec_t'{1, 1, 12'h006, 3'd2, 32'h0,        0, 32'h0,        1, 1});
        tbl.push_back(vec_t'{0, 1, 12'h012, 3'd1, 32'hBEEF0000, 0, 32'h0,        0, 0});
        tbl.push_back(vec_t'{0, 0, 12'h010, 3'd2, 32'h0,        1, 32'hBEEFBEEF, 0, 0});

        foreach (tbl[i]) begin
            xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, 1'b0, rd, r_or, r_and, waits, tmo);
            check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
            check($sformatf("vec%0d_resp", i), {30'd0, r_or, r_and}, {30'd0, tbl[i].er, tbl[i].er});
            check($sformatf("vec%0d_waits", i), 32'(waits), 32'(tbl[i].ew));
            if (tbl[i].chkd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].ed);
        end

        // Back-to-back write then read of the same word on the zero-wait slave.
        @(posedge clk); #1;
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 12'h050; hwrite[0] = 1'b1; hsize[0] = 3'd2;
        @(posedge clk); #1;
        hwdata[0] = 32'hCAFEF00D; hwrite[0] = 1'b0;
        @(negedge clk);
        check("pipe_write_ready", 32'(hreadyout[0]), 32'd1);
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = HTRANS_IDLE;
        @(negedge clk);
        check("pipe_read_ready", 32'(hreadyout[0]), 32'd1);
        check("pipe_read_data", hrdata[0], 32'hCAFEF00D);
        xfer(0, 1'b1, 12'h054, 3'd2, 32'h01020304, 1'b0, rd, r_or, r_and, waits, tmo);
        check("hold_after_write", hrdata[0], 32'hCAFEF00D);

        // Address-phase inputs presented during WAIT must be ignored.
        xfer(1, 1'b1, 12'h064, 3'd2, 32'h64646464, 1'b0, rd, r_or, r_and, waits, tmo);
        xfer(1, 1'b1, 12'h060, 3'd2, 32'h0BADF00D, 1'b1, rd, r_or, r_and, waits, tmo);
        check("junk_waits", 32'(waits), 32'd3);
        xfer(1, 1'b0, 12'h064, 3'd2, 32'h0, 1'b0, rd, r_or, r_and, waits, tmo);
        check("junk_untouched", rd, 32'h64646464);
        xfer(1, 1'b0, 12'h060, 3'd2, 32'h0, 1'b0, rd, r_or, r_and, waits, tmo);
        check("junk_target", rd, 32'h0BADF00D);

        // Reset during the wait of a write aborts it.
        xfer(1, 1'b1, 12'h040, 3'd2, 32'hA5A5A5A5, 1'b0, rd, r_or, r_and, waits, tmo);
        xfer(1, 1'b0, 12'h060, 3'd2, 32'h0, 1'b0, rd, r_or, r_and, waits, tmo);
        @(posedge clk); #1;
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 12'h040; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hwdata[1] = 32'hFFFFFFFF; hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE;
        @(negedge clk);
        check("rst_wait_low", 32'(hreadyout[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_hreadyout", 32'(hreadyout[1]), 32'd1);
        check("rst_hresp", 32'(hresp[1]), 32'd0);
        check("rst_hrdata", hrdata[1], 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(1, 1'b0, 12'h040, 3'd2, 32'h0, 1'b0, rd, r_or, r_and, waits, tmo);
        check("rst_word_kept", rd, 32'hA5A5A5A5);
        check("rst_read_waits", 32'(waits), 32'd3);

        // Fill both memories with known contents, then random traffic.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 256; w++)
                mxfer(d, 1'b1, 12'(w * 4), 3'd2, $urandom);
        for (int n = 0; n < 400; n++) begin
            rs = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) rs = 3'd3;
            if ($urandom_range(0, 9) == 0) ra = 12'h400 + 12'($urandom_range(0, 127));
            else                           ra = 12'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) != 0) ra = ra & ~((12'd1 << rs) - 12'd1);
            mxfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rs, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpsoc_ahb3_spram_ws.md
MPSOC_AHB3_SPRAM_WS -- requirements
Module: mpsoc_ahb3_spram_ws

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: number of XLEN-bit words.
REQ-002 SHALL have parameter PLEN, default 10: address width in bits.
REQ-003 SHALL have parameter XLEN, default 32: data width, 32 or 64.
REQ-004 SHALL have parameter WAIT_STATES, default 0: data-phase wait cycles for OKAY transfers, range 0..7.
REQ-005 SHALL have ports:
- HCLK  in  1  sole clock, rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address.
- HWDATA  in  XLEN  write data, data phase.
- HRDATA  out  XLEN  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HTRANS  in  2  transfer type.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-006 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; on acceptance it SHALL register HADDR, HWRITE and HSIZE.
REQ-007 SHALL answer IDLE, BUSY or unselected transfers with zero-wait OKAY.
REQ-008 SHALL flag an accepted transfer as erroneous when any of these holds:
- the byte address is at or beyond MEM_DEPTH*XLEN/8;
- HSIZE exceeds log2(XLEN/8);
- the address is not aligned to the transfer size.
REQ-009 SHALL implement the FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-010 On an accepted OKAY transfer with WAIT_STATES=0, the FSM SHALL stay in IDLE, keeping HREADYOUT=1.
REQ-011 On an accepted OKAY transfer with WAIT_STATES>0, the FSM SHALL enter WAIT, load a counter with WAIT_STATES-1, and hold HREADYOUT=0.
- The FSM SHALL return to IDLE when the counter reads 0.
- Total data phase SHALL be WAIT_STATES+1 cycles.
REQ-012 On an erroneous transfer the FSM SHALL enter ERR1.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- The FSM SHALL then return to IDLE.
REQ-013 HRESP SHALL be 0 in all states other than ERR1 and ERR2.
REQ-014 Write commit SHALL occur on the final data-phase cycle (HREADYOUT=1, OKAY) and SHALL update only the byte lanes selected by registered HSIZE and address LSBs.
REQ-015 Erroneous writes SHALL NOT modify memory.
REQ-016 Read data for the registered address SHALL be presented on HRDATA in the final data-phase cycle, with all XLEN bits driven from the addressed word.
REQ-017 HRDATA SHALL hold its last value when no read is in its final data phase.
REQ-018 A read immediately following a write to the same word SHALL return the newly written bytes.
REQ-019 A new address phase coinciding with a final data phase (pipelined) SHALL be accepted without an extra bubble.
REQ-020 During WAIT/ERR1 (HREADY=0) address-phase inputs SHALL be ignored.

Reset
REQ-021 On HRESETn=0, asynchronously:
- the FSM SHALL go to IDLE and the counter to 0;
- HREADYOUT SHALL be 1, HRESP 0 and HRDATA 0;
- registered control SHALL be cleared.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer without a memory write; memory contents are not reset.

Structure
REQ-023 A shared package SHALL hold the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), the HRESP codes and the FSM state enum.
REQ-024 The memory array SHALL be a sub-module mpsoc_ram_1r1w_be, with a byte-enabled write port and an asynchronous read port.

Verification
REQ-025 WAIT_STATES=0: write 0xDEADBEEF to 0x010, then read 0x010 -> HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=0.
REQ-026 WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, data valid on cycle 4.
REQ-027 Byte writes 0x11 at 0x020 and 0x22 at 0x023 over word 0x00000000 -> read 0x020 returns 0x22000011.
REQ-028 MEM_DEPTH=256, write to 0x400 -> ERR1 then ERR2, HRESP=1 both cycles; a subsequent read of 0x000 is unchanged.
REQ-029 Halfword access at 0x001 -> two-cycle ERROR; word 0x000 is unchanged.
REQ-030 Assert HRESETn=0 during WAIT of a write -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the target word is unchanged.
